// File: rtl/multiword_addsub_sequencer.sv
// Multi-word add/subtract: one DATA_WIDTH-bit ripple slice reused over NUM_WORDS cycles.
// Optional ADDSEQ_BACK_TO_BACK_EN lets a new operation be accepted on the result handoff edge.
module multiword_addsub_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic                            op_sub,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] A,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] B,
  output logic                            done_valid,
  input  logic                            done_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] S,
  output logic                            CF,
  output logic                            OF
);

  localparam int unsigned W  = DATA_WIDTH * NUM_WORDS;
  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  idle_q, done_q;
  logic [IW-1:0]         idx_q;
  logic                  carry_q;
  logic [W-1:0]          opa_q, opb_q;
  logic [DATA_WIDTH-1:0] a_w, b_w, lo_sum, sum_w;
  logic [1:0]            top_sum;
  logic                  cout_w, of_w, last_w, start_fire;

  assign done_valid = done_q;
`ifdef ADDSEQ_BACK_TO_BACK_EN
  assign start_ready = idle_q | (done_q & done_ready);
`else
  assign start_ready = idle_q;
`endif
  assign start_fire = start_valid & start_ready;
  assign last_w     = (idx_q == LAST_IDX);

  // Shared adder slice; carry into the MSB is split out so OF can be formed.
  always_comb begin
    a_w     = opa_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    b_w     = opb_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    lo_sum  = {1'b0, a_w[DATA_WIDTH-2:0]} + {1'b0, b_w[DATA_WIDTH-2:0]}
            + DATA_WIDTH'(carry_q);
    top_sum = 2'(a_w[DATA_WIDTH-1]) + 2'(b_w[DATA_WIDTH-1]) + 2'(lo_sum[DATA_WIDTH-1]);
    sum_w   = {top_sum[0], lo_sum[DATA_WIDTH-2:0]};
    cout_w  = top_sum[1];
    of_w    = lo_sum[DATA_WIDTH-1] ^ top_sum[1];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_valid) state_d = ST_RUN;
      ST_RUN:  if (last_w) state_d = ST_DONE;
      ST_DONE: begin
        if (done_ready) begin
`ifdef ADDSEQ_BACK_TO_BACK_EN
          state_d = start_valid ? ST_RUN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with registered handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Operand capture and word-serial result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      S       <= '0;
      CF      <= 1'b0;
      OF      <= 1'b0;
    end else if (start_fire) begin
      opa_q   <= A;
      opb_q   <= B ^ {W{op_sub}};
      carry_q <= op_sub;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      S[idx_q*DATA_WIDTH +: DATA_WIDTH] <= sum_w;
      carry_q <= cout_w;
      idx_q   <= last_w ? '0 : idx_q + IW'(1);
      if (last_w) begin
        CF <= cout_w;
        OF <= of_w;
      end
    end
  end

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Scoreboard bench for multiword_addsub_sequencer (DATA_WIDTH=16, NUM_WORDS=4).
module tb_multiword_addsub_sequencer;

  typedef struct packed {
    logic [63:0] s;
    logic        cf;
    logic        of;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready, op_sub;
  logic [63:0] A, B, S;
  logic        done_valid, done_ready, CF, OF;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multiword_addsub_sequencer #(.DATA_WIDTH(16), .NUM_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_sub(op_sub), .A(A), .B(B),
    .done_valid(done_valid), .done_ready(done_ready),
    .S(S), .CF(CF), .OF(OF)
  );

  // Reference: plain 64-bit arithmetic on the whole operands.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
    exp_t e;
    logic [64:0] wide;
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b};
      e.s  = wide[63:0];
      e.cf = wide[64];
      e.of = (a[63] == b[63]) && (e.s[63] != a[63]);
    end else begin
      e.s  = a - b;
      e.cf = (a >= b);
      e.of = (a[63] != b[63]) && (e.s[63] != a[63]);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_S", S, e.s);
        chk("result_CF", 64'(CF), 64'(e.cf));
        chk("result_OF", 64'(OF), 64'(e.of));
      end
    end
  end

  // Wait at negedges for start_ready, bounded.
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) chk("start_ready_timeout", 64'(start_ready), 64'(1));
  endtask

  // Count edges until done_valid is seen, bounded; called #1 after an edge.
  task automatic wait_done(input int first, output int n);
    n = first;
    while (!done_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one operation, hold the result for `hold` cycles, then consume it.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub, input int hold);
    exp_t e;
    int n;
    e = model(a, b, sub);
    A = a; B = b; op_sub = sub; start_valid = 1'b1; done_ready = 1'b0;
    wait_ready();
    @(posedge clk);
    sb.push_back(e);
    #1;
    start_valid = 1'b0;
    A = ~a; B = {$urandom, $urandom}; op_sub = ~sub;
    wait_done(0, n);
    chk("latency", 64'(n), 64'(4));
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      @(negedge clk);
      chk("bp_S", S, e.s);
      chk("bp_CF", 64'(CF), 64'(e.cf));
      chk("bp_OF", 64'(OF), 64'(e.of));
      chk("bp_start_ready", 64'(start_ready), 64'(0));
      chk("bp_done_valid", 64'(done_valid), 64'(1));
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("after_done_start_ready", 64'(start_ready), 64'(1));
    chk("after_done_valid", 64'(done_valid), 64'(0));
  endtask

  task automatic reset_mid_op();
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; op_sub = 1'b0;
    start_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_start_ready", 64'(start_ready), 64'(1));
    chk("rst_mid_done_valid", 64'(done_valid), 64'(0));
    chk("rst_mid_S", S, 64'(0));
    chk("rst_mid_CF", 64'(CF), 64'(0));
    chk("rst_mid_OF", 64'(OF), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef ADDSEQ_BACK_TO_BACK_EN
  task automatic back_to_back();
    int n;
    A = 64'd1; B = 64'd1; op_sub = 1'b0; start_valid = 1'b1; done_ready = 1'b1;
    wait_ready();
    @(posedge clk);
    sb.push_back(model(64'd1, 64'd1, 1'b0));
    #1;
    A = 64'd2; B = 64'd2;
    wait_done(0, n);
    chk("btb_first_latency", 64'(n), 64'(4));
    @(posedge clk);
    sb.push_back(model(64'd2, 64'd2, 1'b0));
    #1;
    start_valid = 1'b0;
    wait_done(1, n);
    chk("btb_period", 64'(n), 64'(5));
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask
`endif

  initial begin
    int n;
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; op_sub = 1'b0;
    A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_start_ready", 64'(start_ready), 64'(1));
    chk("reset_done_valid", 64'(done_valid), 64'(0));
    chk("reset_S", S, 64'(0));
    chk("reset_CF", 64'(CF), 64'(0));
    chk("reset_OF", 64'(OF), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // done_ready outside DONE must not produce a result
    done_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_valid", 64'(done_valid), 64'(0));
      @(posedge clk); #1;
    end
    done_ready = 1'b0;

    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2);
    issue(64'h5, 64'h7, 1'b1, 0);
    issue(64'h7, 64'h5, 1'b1, 1);
    issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 0);
    issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 10);

    reset_mid_op();
    issue(64'd3, 64'd4, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'(~ra) : {$urandom, $urandom};
      issue(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

`ifdef ADDSEQ_BACK_TO_BACK_EN
    back_to_back();
`endif

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
